pipeline_m: RTL and testbench

PIPELINE_M -- requirements
Module: pipeline_m

---
 rtl/pipeline_m.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_m.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_m.sv
// pipeline_m -- E/M pipeline register plus the M-stage data memory.
//
// Ports
//   clk          : single clock; all state updates on the rising edge
//   reset        : asynchronous, active-low; clears the E/M register and every memory word
//   Instr_E      : instruction leaving E
//   ALUOutput    : E result (memory address for loads/stores, PC+8 for links)
//   WriteData_E  : rt value from E (store data candidate)
//   WriteRd_E    : destination register from E
//   PCPlus4_E    : PC+4 of the instruction in E
//   FlushM       : synchronous bubble insert into the E/M register
//   ForwardRTM   : store data select (0 registered rt, 1 MUXRFWDOut)
//   MUXRFWDOut   : W-stage write-back value
//   Instr_M, ALUOutput_M, PCPlus4_M, WriteRd_M : registered E/M copies
//   ReadData_M   : load result, byte/half selected and extended
//
// Memory reads are combinational, so a load one cycle behind a store to
// the same word sees the stored data. A store commits at the edge that
// ends its M cycle; an asserted reset wins over that edge.
module pipeline_m #(
  parameter int          DM_WORDS = 1024,
  parameter logic [31:0] PC_BASE  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] ALUOutput,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WriteRd_E,
  input  logic [31:0] PCPlus4_E,
  input  logic        FlushM,
  input  logic        ForwardRTM,
  input  logic [31:0] MUXRFWDOut,
  output logic [31:0] Instr_M,
  output logic [31:0] ALUOutput_M,
  output logic [31:0] PCPlus4_M,
  output logic [4:0]  WriteRd_M,
  output logic [31:0] ReadData_M
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  // E/M register
  logic [31:0] instr_m_q, instr_m_d;
  logic [31:0] alu_out_m_q, alu_out_m_d;
  logic [31:0] write_data_m_q, write_data_m_d;
  logic [4:0]  write_rd_m_q, write_rd_m_d;
  logic [31:0] pc_plus4_m_q, pc_plus4_m_d;

  always_comb begin
    instr_m_d      = Instr_E;
    alu_out_m_d    = ALUOutput;
    write_data_m_d = WriteData_E;
    write_rd_m_d   = WriteRd_E;
    pc_plus4_m_d   = PCPlus4_E;
    if (FlushM) begin
      // A flushed slot becomes a nop; PC+4 still advances with E.
      instr_m_d      = '0;
      alu_out_m_d    = '0;
      write_data_m_d = '0;
      write_rd_m_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_m_q      <= '0;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_rd_m_q   <= '0;
      pc_plus4_m_q   <= '0;
    end else begin
      instr_m_q      <= instr_m_d;
      alu_out_m_q    <= alu_out_m_d;
      write_data_m_q <= write_data_m_d;
      write_rd_m_q   <= write_rd_m_d;
      pc_plus4_m_q   <= pc_plus4_m_d;
    end
  end

  assign Instr_M     = instr_m_q;
  assign ALUOutput_M = alu_out_m_q;
  assign PCPlus4_M   = pc_plus4_m_q;
  assign WriteRd_M   = write_rd_m_q;

  // M-stage data memory
  logic [31:0]   mem_q [DM_WORDS];
  logic [5:0]    op_m;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic [31:0]   raw_word;
  logic [31:0]   store_data;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic          wr_en;
  logic [31:0]   wr_word;

  assign op_m     = instr_m_q[31:26];
  // Upper address bits are ignored, so accesses wrap modulo DM_WORDS.
  assign word_idx = alu_out_m_q[AW+1:2];
  assign byte_off = alu_out_m_q[1:0];
  assign raw_word = mem_q[word_idx];

  always_comb begin
    store_data = ForwardRTM ? MUXRFWDOut : write_data_m_q;

    rd_half = byte_off[1] ? raw_word[31:16] : raw_word[15:0];
    case (byte_off)
      2'd0:    rd_byte = raw_word[7:0];
      2'd1:    rd_byte = raw_word[15:8];
      2'd2:    rd_byte = raw_word[23:16];
      default: rd_byte = raw_word[31:24];
    endcase

    // Non-loads present the raw addressed word.
    case (op_m)
      OP_LH:   ReadData_M = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ReadData_M = {16'h0000, rd_half};
      OP_LB:   ReadData_M = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ReadData_M = {24'h000000, rd_byte};
      default: ReadData_M = raw_word;
    endcase

    // Merge the store into the current word; wr_word is the full word after the write.
    wr_en   = 1'b0;
    wr_word = raw_word;
    case (op_m)
      OP_SW: begin
        wr_en   = 1'b1;
        wr_word = store_data;
      end
      OP_SH: begin
        wr_en = 1'b1;
        if (byte_off[1]) wr_word[31:16] = store_data[15:0];
        else             wr_word[15:0]  = store_data[15:0];
      end
      OP_SB: begin
        wr_en = 1'b1;
        case (byte_off)
          2'd0:    wr_word[7:0]   = store_data[7:0];
          2'd1:    wr_word[15:8]  = store_data[7:0];
          2'd2:    wr_word[23:16] = store_data[7:0];
          default: wr_word[31:24] = store_data[7:0];
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word;
    end
  end

`ifndef SYNTHESIS
  // Write trace: one line per committed store.
  logic [31:0] trace_pc;
  assign trace_pc = pc_plus4_m_q - 32'd4;

  always @(posedge clk) begin
    if (reset && wr_en) begin
      $display("@%h: *%h <= %h", trace_pc, {alu_out_m_q[31:2], 2'b00}, wr_word);
      if (trace_pc < PC_BASE)
        $display("note: store PC %h lies below text base %h", trace_pc, PC_BASE);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_m.sv
// Directed bench for pipeline_m. A driver issues one instruction per cycle
// into E and queues what the M stage must show one cycle later; a monitor
// pops the queue on each falling edge and compares.
module tb_pipeline_m;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_E, ALUOutput, WriteData_E, PCPlus4_E, MUXRFWDOut;
  logic [4:0]  WriteRd_E;
  logic        FlushM, ForwardRTM;
  logic [31:0] Instr_M, ALUOutput_M, PCPlus4_M, ReadData_M;
  logic [4:0]  WriteRd_M;

  pipeline_m dut (
    .clk(clk), .reset(reset),
    .Instr_E(Instr_E), .ALUOutput(ALUOutput), .WriteData_E(WriteData_E),
    .WriteRd_E(WriteRd_E), .PCPlus4_E(PCPlus4_E), .FlushM(FlushM),
    .ForwardRTM(ForwardRTM), .MUXRFWDOut(MUXRFWDOut),
    .Instr_M(Instr_M), .ALUOutput_M(ALUOutput_M), .PCPlus4_M(PCPlus4_M),
    .WriteRd_M(WriteRd_M), .ReadData_M(ReadData_M)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // sel: 0 ReadData_M, 1 Instr_M, 2 ALUOutput_M, 3 PCPlus4_M, 4 WriteRd_M
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else             n_pass++;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 5'd4, 5'd8, 16'h0000};
  endfunction

  function automatic void push(input int c, input int sel, input logic [31:0] exp);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.exp = exp;
    exp_q.push_back(e);
  endfunction

  // driver: fwd/mux apply to the instruction currently in M
  task automatic issue(input logic [31:0] instr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic flush,
                       input logic fwd, input logic [31:0] mux,
                       input logic chk_rd, input logic [31:0] exp_rd);
    int c;
    @(negedge clk);
    Instr_E     = instr;
    ALUOutput   = alu;
    WriteData_E = wd;
    WriteRd_E   = rd;
    PCPlus4_E   = pc4;
    FlushM      = flush;
    ForwardRTM  = fwd;
    MUXRFWDOut  = mux;
    c = cyc + 1;
    push(c, 1, flush ? 32'h0 : instr);
    push(c, 2, flush ? 32'h0 : alu);
    push(c, 3, pc4);
    push(c, 4, flush ? 32'h0 : {27'h0, rd});
    if (chk_rd) push(c, 0, exp_rd);
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"}, Instr_M, 32'h0);
    check({tag, "_alu"},   ALUOutput_M, 32'h0);
    check({tag, "_pc4"},   PCPlus4_M, 32'h0);
    check({tag, "_rd"},    {27'h0, WriteRd_M}, 32'h0);
    check({tag, "_rdata"}, ReadData_M, 32'h0);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    logic [31:0] act;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        case (e.sel)
          0:       begin act = ReadData_M;            nm = "ReadData_M";  end
          1:       begin act = Instr_M;               nm = "Instr_M";     end
          2:       begin act = ALUOutput_M;           nm = "ALUOutput_M"; end
          3:       begin act = PCPlus4_M;             nm = "PCPlus4_M";   end
          default: begin act = {27'h0, WriteRd_M};    nm = "WriteRd_M";   end
        endcase
        if (e.cyc != cyc) begin
          n_checks++;
          $display("FAIL stale_%s: entry for cycle %0d seen at cycle %0d", nm, e.cyc, cyc);
        end else begin
          check($sformatf("%s@%0d", nm, cyc), act, e.exp);
        end
      end
    end
  end

  // stimulus
  initial begin
    int waited;
    reset = 1'b0;
    Instr_E = '0; ALUOutput = '0; WriteData_E = '0; WriteRd_E = '0;
    PCPlus4_E = 32'h0000_3004; FlushM = 1'b0; ForwardRTM = 1'b0; MUXRFWDOut = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 check("reset_hold_pc4", PCPlus4_M, 32'h0);
    @(negedge clk) reset = 1'b1;

    // sw 12345678 at 0x10; raw word is still 0 while the store sits in M
    issue(mk(OP_SW),  32'h10, 32'h1234_5678, 5'd0, 32'h3004, 0, 0, 0, 1, 32'h0);
    issue(mk(OP_LW),  32'h10, 32'h0, 5'd9, 32'h3008, 0, 0, 0, 1, 32'h1234_5678);
    // sb AB at 0x13 (upper data bits must be ignored)
    issue(mk(OP_SB),  32'h13, 32'hFFFF_FFAB, 5'd0, 32'h300C, 0, 0, 0, 0, 32'h0);
    issue(mk(OP_LW),  32'h10, 32'h0, 5'd9, 32'h3010, 0, 0, 0, 1, 32'hAB34_5678);
    issue(mk(OP_LB),  32'h13, 32'h0, 5'd9, 32'h3014, 0, 0, 0, 1, 32'hFFFF_FFAB);
    issue(mk(OP_LBU), 32'h13, 32'h0, 5'd9, 32'h3018, 0, 0, 0, 1, 32'h0000_00AB);
    // sh 8001 at 0x12 -> upper half; low half keeps 5678
    issue(mk(OP_SH),  32'h12, 32'h5555_8001, 5'd0, 32'h301C, 0, 0, 0, 0, 32'h0);
    issue(mk(OP_LH),  32'h12, 32'h0, 5'd9, 32'h3020, 0, 0, 0, 1, 32'hFFFF_8001);
    issue(mk(OP_LHU), 32'h12, 32'h0, 5'd9, 32'h3024, 0, 0, 0, 1, 32'h0000_8001);
    issue(mk(OP_LH),  32'h13, 32'h0, 5'd9, 32'h3028, 0, 0, 0, 1, 32'hFFFF_8001);
    issue(mk(OP_LW),  32'h10, 32'h0, 5'd9, 32'h302C, 0, 0, 0, 1, 32'h8001_5678);
    // link instruction: non-memory, raw word at wrapped index (0x2010 -> word 0x10)
    issue(mk(OP_JAL), 32'h2010, 32'h0, 5'd31, 32'h3030, 0, 0, 0, 1, 32'h8001_5678);
    // sw with registered data 0, forwarded DEADBEEF during its M cycle
    issue(mk(OP_SW),  32'h20, 32'h0, 5'd0, 32'h3034, 0, 0, 0, 1, 32'h0);
    issue(mk(OP_LW),  32'h20, 32'h0, 5'd9, 32'h3038, 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
    issue(mk(OP_LB),  32'h20, 32'h0, 5'd9, 32'h303C, 0, 0, 0, 1, 32'hFFFF_FFEF);
    issue(mk(OP_LBU), 32'h21, 32'h0, 5'd9, 32'h3040, 0, 0, 0, 1, 32'h0000_00BE);
    issue(mk(OP_LH),  32'h1020, 32'h0, 5'd9, 32'h3044, 0, 0, 0, 1, 32'hFFFF_BEEF);
    // flushed sw: nop in M, reads word 0, must not write 0x30
    issue(mk(OP_SW),  32'h30, 32'h1111_1111, 5'd7, 32'h3100, 1, 0, 0, 1, 32'h0);
    issue(mk(OP_LW),  32'h30, 32'h0, 5'd9, 32'h3104, 0, 0, 0, 1, 32'h0);

    // store in M, reset pulled low before its commit edge
    issue(mk(OP_SW),  32'h40, 32'hCAFE_BABE, 5'd0, 32'h3108, 0, 0, 0, 1, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    Instr_E = '0; ALUOutput = '0; WriteData_E = '0; WriteRd_E = '0;
    FlushM = 1'b1; PCPlus4_E = 32'h0000_1234;
    #1 check_all_zero("mid_reset");
    @(posedge clk);
    #1 check("reset_flush_pc4", PCPlus4_M, 32'h0);
    check("reset_mem_word10", ReadData_M, 32'h0);
    @(negedge clk);
    FlushM = 1'b0;
    reset = 1'b1;

    issue(mk(OP_LW),  32'h40, 32'h0, 5'd9, 32'h3200, 0, 0, 0, 1, 32'h0);
    issue(mk(OP_LW),  32'h10, 32'h0, 5'd9, 32'h3204, 0, 0, 0, 1, 32'h0);
    issue(mk(OP_LW),  32'h20, 32'h0, 5'd9, 32'h3208, 0, 0, 0, 0, 32'h0);
    issue(32'h0,      32'h0,  32'h0, 5'd0, 32'h320C, 0, 0, 0, 1, 32'h0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
